// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: holds architectural HI/LO, computes the result
// at issue and releases it to HI/LO after a fixed busy latency.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic             pend_wr_q, pend_wr_d;

  logic        accept;
  logic [63:0] prod_s, prod_u;
  logic        is_sdiv, rs_neg, rt_neg, div_zero;
  logic [31:0] rs_mag, rt_mag, dvd, dvs, uq, ur, div_q, div_r;

  // Low 64 bits of the product of sign-extended operands equal the signed product.
  assign prod_s = {{32{rs_data[31]}}, rs_data} * {{32{rt_data[31]}}, rt_data};
  assign prod_u = {32'b0, rs_data} * {32'b0, rt_data};

  // One unsigned divider serves both flavours; signed div works on magnitudes
  // so 0x80000000 / -1 lands on 0x80000000 without overflow.
  assign is_sdiv  = (op == OP_DIV);
  assign rs_neg   = is_sdiv & rs_data[31];
  assign rt_neg   = is_sdiv & rt_data[31];
  assign rs_mag   = rs_neg ? -rs_data : rs_data;
  assign rt_mag   = rt_neg ? -rt_data : rt_data;
  assign div_zero = (rt_data == 32'd0);
  assign dvd      = rs_mag;
  assign dvs      = div_zero ? 32'd1 : rt_mag;
  assign uq       = dvd / dvs;
  assign ur       = dvd % dvs;
  assign div_q    = (rs_neg ^ rt_neg) ? -uq : uq;
  assign div_r    = rs_neg ? -ur : ur;

  assign accept = (state_q == S_IDLE) && start && !flush;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (op)
            OP_MULT: begin
              pend_hi_d = prod_s[63:32];
              pend_lo_d = prod_s[31:0];
              pend_wr_d = 1'b1;
              cnt_d     = MULT_LOAD;
              state_d   = S_BUSY;
            end
            OP_MULTU: begin
              pend_hi_d = prod_u[63:32];
              pend_lo_d = prod_u[31:0];
              pend_wr_d = 1'b1;
              cnt_d     = MULT_LOAD;
              state_d   = S_BUSY;
            end
            OP_DIV, OP_DIVU: begin
              pend_hi_d = div_r;
              pend_lo_d = div_q;
              pend_wr_d = !div_zero;
              cnt_d     = DIV_LOAD;
              state_d   = S_BUSY;
            end
            OP_MTHI: hi_d = rs_data;
            OP_MTLO: lo_d = rs_data;
            default: ;
          endcase
        end
      end
      S_BUSY: begin
        if (cnt_q <= CNT_ONE) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  assign busy = (state_q == S_BUSY);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: expected HI/LO and busy length are queued
// at issue and compared when the operation retires.
module tb_mdu_ctrl;

  localparam logic [2:0] OP_NONE  = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;
  localparam logic [2:0] OP_RSVD  = 3'b111;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [2:0]  op;
  logic [31:0] rs_data, rt_data;
  logic        busy;
  logic [31:0] hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] mdl_hi = '0;
  logic [31:0] mdl_lo = '0;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .flush(flush),
    .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    tick();
    start = 1'b0; op = OP_NONE;
  endtask

  task automatic wait_idle(output int n, output bit to);
    n = 0; to = 1'b0;
    while (busy === 1'b1 && !to) begin
      n++;
      tick();
      if (n > 100) to = 1'b1;
    end
  endtask

  // Reference model: 64-bit arithmetic, independent of the DUT's magnitude divider.
  function automatic exp_t model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa, sb_, p, q, r;
    logic [63:0] pu;
    sa = longint'($signed(a));
    sb_ = longint'($signed(b));
    e.hi = mdl_hi; e.lo = mdl_lo; e.cyc = 0;
    case (o)
      OP_MULT:  begin p = sa * sb_; e.hi = p[63:32]; e.lo = p[31:0]; e.cyc = 5; end
      OP_MULTU: begin pu = 64'(a) * 64'(b); e.hi = pu[63:32]; e.lo = pu[31:0]; e.cyc = 5; end
      OP_DIV: begin
        e.cyc = 10;
        if (b != 0) begin q = sa / sb_; r = sa % sb_; e.lo = q[31:0]; e.hi = r[31:0]; end
      end
      OP_DIVU: begin
        e.cyc = 10;
        if (b != 0) begin e.lo = a / b; e.hi = a % b; end
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic push_exp(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e = model(o, a, b);
    sb.push_back(e);
    mdl_hi = e.hi; mdl_lo = e.lo;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; flush = 1'b0; op = OP_NONE; rs_data = '0; rt_data = '0;
    tick(); tick();
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: busy=%b hi=%h lo=%h, need busy=0 hi=0 lo=0", busy, hi, lo);
    end
    mdl_hi = '0; mdl_lo = '0;
  endtask

  task automatic test_mult();
    int n; bit to; exp_t e;
    push_exp(OP_MULT, 32'hFFFFFFFF, 32'd2);
    issue(OP_MULT, 32'hFFFFFFFF, 32'd2);
    wait_idle(n, to);
    e = sb.pop_front();
    checks++;
    if (to || n != e.cyc || n != 5) begin
      errors++; $display("FAIL mult_busy: cycles=%0d timeout=%0b, need 5", n, to);
    end
    checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFE || hi !== e.hi || lo !== e.lo) begin
      errors++; $display("FAIL mult_result: hi=%h lo=%h, need hi=ffffffff lo=fffffffe", hi, lo);
    end
    push_exp(OP_MULTU, 32'hFFFFFFFF, 32'd2);
    issue(OP_MULTU, 32'hFFFFFFFF, 32'd2);
    wait_idle(n, to);
    e = sb.pop_front();
    checks++;
    if (to || n != 5 || hi !== 32'h00000001 || lo !== 32'hFFFFFFFE || hi !== e.hi || lo !== e.lo) begin
      errors++; $display("FAIL multu_result: cycles=%0d hi=%h lo=%h, need 5 hi=00000001 lo=fffffffe", n, hi, lo);
    end
  endtask

  task automatic test_div();
    int n; bit to; exp_t e;
    push_exp(OP_DIV, 32'hFFFFFFF9, 32'd2);
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
    wait_idle(n, to);
    e = sb.pop_front();
    checks++;
    if (to || n != 10) begin
      errors++; $display("FAIL div_busy: cycles=%0d timeout=%0b, need 10", n, to);
    end
    checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD || hi !== e.hi || lo !== e.lo) begin
      errors++; $display("FAIL div_result: hi=%h lo=%h, need hi=ffffffff lo=fffffffd", hi, lo);
    end
    push_exp(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(n, to);
    e = sb.pop_front();
    checks++;
    if (to || n != 10 || hi !== 32'h0 || lo !== 32'h80000000 || hi !== e.hi || lo !== e.lo) begin
      errors++; $display("FAIL div_overflow: cycles=%0d hi=%h lo=%h, need 10 hi=0 lo=80000000", n, hi, lo);
    end
  endtask

  task automatic test_mthi_mtlo();
    logic [31:0] lo_prev;
    lo_prev = mdl_lo;
    start = 1'b1; op = OP_MTHI; rs_data = 32'h12345678;
    tick();
    checks++;
    if (hi !== 32'h12345678 || lo !== lo_prev || busy !== 1'b0) begin
      errors++; $display("FAIL mthi: hi=%h lo=%h busy=%b, need hi=12345678 lo=%h busy=0", hi, lo, busy, lo_prev);
    end
    op = OP_MTLO; rs_data = 32'h9ABCDEF0;
    tick();
    start = 1'b0; op = OP_NONE;
    checks++;
    if (hi !== 32'h12345678 || lo !== 32'h9ABCDEF0 || busy !== 1'b0) begin
      errors++; $display("FAIL mtlo: hi=%h lo=%h busy=%b, need hi=12345678 lo=9abcdef0 busy=0", hi, lo, busy);
    end
    mdl_hi = 32'h12345678; mdl_lo = 32'h9ABCDEF0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL mt_busy: busy=%b, need 0", busy);
    end
  endtask

  task automatic test_noop();
    start = 1'b1; op = OP_NONE; rs_data = 32'hDEADBEEF; rt_data = 32'd3;
    tick();
    op = OP_RSVD;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || hi !== mdl_hi || lo !== mdl_lo) begin
      errors++; $display("FAIL noop: busy=%b hi=%h lo=%h, need 0 %h %h", busy, hi, lo, mdl_hi, mdl_lo);
    end
  endtask

  task automatic test_flush();
    int n; bit to; exp_t e;
    start = 1'b1; op = OP_MULT; rs_data = 32'd7; rt_data = 32'd9; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0; op = OP_NONE;
    checks++;
    if (busy !== 1'b0 || hi !== mdl_hi || lo !== mdl_lo) begin
      errors++; $display("FAIL flush_issue: busy=%b hi=%h lo=%h, need 0 %h %h", busy, hi, lo, mdl_hi, mdl_lo);
    end
    push_exp(OP_MULT, 32'd1000, 32'hFFFFFFFD);
    issue(OP_MULT, 32'd1000, 32'hFFFFFFFD);
    tick();
    flush = 1'b1; start = 1'b1; op = OP_DIV;
    tick();
    flush = 1'b0; start = 1'b0; op = OP_NONE;
    wait_idle(n, to);
    e = sb.pop_front();
    checks++;
    if (to || n + 2 != 5 || hi !== e.hi || lo !== e.lo) begin
      errors++; $display("FAIL flush_busy: cycles=%0d hi=%h lo=%h, need 5 %h %h", n + 2, hi, lo, e.hi, e.lo);
    end
  endtask

  task automatic test_divu_zero();
    int n; bit to; exp_t e;
    issue(OP_MTHI, 32'h0000AAAA, 32'd0);
    issue(OP_MTLO, 32'h00005555, 32'd0);
    mdl_hi = 32'h0000AAAA; mdl_lo = 32'h00005555;
    push_exp(OP_DIVU, 32'd12345, 32'd0);
    issue(OP_DIVU, 32'd12345, 32'd0);
    wait_idle(n, to);
    e = sb.pop_front();
    checks++;
    if (to || n != 10 || hi !== 32'h0000AAAA || lo !== 32'h00005555 || hi !== e.hi || lo !== e.lo) begin
      errors++; $display("FAIL divu_zero: cycles=%0d hi=%h lo=%h, need 10 0000aaaa 00005555", n, hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    int n; bit to; exp_t e;
    push_exp(OP_MULTU, 32'h00010000, 32'h00010000);
    start = 1'b1; op = OP_MULTU; rs_data = 32'h00010000; rt_data = 32'h00010000;
    tick();
    wait_idle(n, to);
    e = sb.pop_front();
    checks++;
    if (to || n != 5 || busy !== 1'b0 || hi !== e.hi || lo !== e.lo) begin
      errors++; $display("FAIL b2b_first: cycles=%0d busy=%b hi=%h lo=%h, need 5 0 %h %h", n, busy, hi, lo, e.hi, e.lo);
    end
    push_exp(OP_DIVU, 32'd100, 32'd7);
    op = OP_DIVU; rs_data = 32'd100; rt_data = 32'd7;
    tick();
    start = 1'b0; op = OP_NONE;
    wait_idle(n, to);
    e = sb.pop_front();
    checks++;
    if (to || n != 10 || hi !== e.hi || lo !== e.lo) begin
      errors++; $display("FAIL b2b_second: cycles=%0d hi=%h lo=%h, need 10 %h %h", n, hi, lo, e.hi, e.lo);
    end
  endtask

  task automatic test_random();
    int n; bit to; exp_t e;
    logic [2:0]  o;
    logic [31:0] a, b;
    for (int i = 0; i < 12; i++) begin
      o = 3'(1 + $urandom_range(0, 3));
      a = $urandom;
      b = (i % 4 == 3) ? 32'($urandom_range(0, 3)) : $urandom;
      push_exp(o, a, b);
      issue(o, a, b);
      wait_idle(n, to);
      e = sb.pop_front();
      checks++;
      if (to || n != e.cyc || hi !== e.hi || lo !== e.lo) begin
        errors++;
        $display("FAIL random_op%0d: op=%0d a=%h b=%h cycles=%0d hi=%h lo=%h, need %0d %h %h",
                 i, o, a, b, n, hi, lo, e.cyc, e.hi, e.lo);
      end
    end
  endtask

  task automatic test_reset_midop();
    issue(OP_MTHI, 32'h00000011, 32'd0);
    issue(OP_MTLO, 32'h00000022, 32'd0);
    issue(OP_DIV, 32'd100, 32'd7);
    tick();
    tick();
    reset = 1'b1; start = 1'b1; op = OP_MTHI; rs_data = 32'hDEAD0001;
    tick();
    checks++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      errors++; $display("FAIL reset_midop: busy=%b hi=%h lo=%h, need 0 0 0", busy, hi, lo);
    end
    reset = 1'b0; start = 1'b0; op = OP_NONE;
    for (int i = 0; i < 12; i++) tick();
    checks++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      errors++; $display("FAIL reset_discard: busy=%b hi=%h lo=%h, need 0 0 0", busy, hi, lo);
    end
    mdl_hi = '0; mdl_lo = '0;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mthi_mtlo();
    test_noop();
    test_flush();
    test_divu_zero();
    test_back_to_back();
    test_random();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 The block SHALL have parameter MULT_CYCLES, default 5, giving the number of busy cycles for mult/multu.
REQ-002 The block SHALL have parameter DIV_CYCLES, default 10, giving the number of busy cycles for div/divu.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit: an MD instruction is issued this cycle.
REQ-007 The block SHALL have port op, input, 3 bits, encoded as follows.
- 000 none; 001 mult; 010 multu; 011 div; 100 divu; 101 mthi; 110 mtlo; 111 reserved.
REQ-008 The block SHALL have port rs_data, input, 32 bits: first operand (dividend for div/divu; source value for mthi/mtlo).
REQ-009 The block SHALL have port rt_data, input, 32 bits: second operand (divisor for div/divu).
REQ-010 The block SHALL have port flush, input, 1 bit: an exception or eret is cancelling the instruction in this stage.
REQ-011 The block SHALL have port busy, output, 1 bit: a multi-cycle operation is in flight; the hazard unit stalls mfhi/mflo/MD issue on it.
REQ-012 The block SHALL have port hi, output, 32 bits: the architectural HI register.
REQ-013 The block SHALL have port lo, output, 32 bits: the architectural LO register.

Function
REQ-014 The block SHALL implement a two-state FSM with states IDLE and BUSY, plus a down-counter sized for max(MULT_CYCLES, DIV_CYCLES).
REQ-015 An issue SHALL be accepted only when the FSM is in IDLE, start=1 and flush=0.
- In any other case start is ignored and no state changes.
REQ-016 On an accepted mult/multu/div/divu, at the same edge the block SHALL:
- capture the result into internal pending registers;
- load the counter with the cycle count;
- enter BUSY.
REQ-017 busy SHALL be 1 for exactly N consecutive cycles starting the cycle after acceptance, where N = MULT_CYCLES or DIV_CYCLES.
- busy SHALL be combinationally equal to (state==BUSY).
REQ-018 hi and lo SHALL take the pending result at the edge that ends the last busy cycle, and SHALL be unchanged throughout BUSY.
REQ-019 mult SHALL form the signed 64-bit product of rs_data and rt_data; multu SHALL form the unsigned 64-bit product.
- In both cases hi = product[63:32] and lo = product[31:0].
REQ-020 div SHALL be signed, with lo = quotient truncated toward zero and hi = remainder carrying the sign of the dividend.
- divu SHALL be unsigned, with lo = quotient and hi = remainder.
REQ-021 div/divu with rt_data=0 SHALL still occupy DIV_CYCLES busy cycles and SHALL leave hi and lo unchanged.
REQ-022 Signed div of 0x80000000 by 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0.
REQ-023 An accepted mthi SHALL write rs_data to hi at the next edge, leave lo unchanged, remain in IDLE and never assert busy.
- mtlo SHALL behave the same way, writing lo and leaving hi unchanged.
REQ-024 op=000 or op=111 with start=1 SHALL be a no-op.
REQ-025 flush SHALL cancel only a same-cycle issue; an operation already in BUSY SHALL complete and update hi/lo normally.
REQ-026 On the edge that leaves BUSY, a new start SHALL NOT be accepted; it is accepted in the first IDLE cycle.
- Back-to-back ops therefore have a minimum spacing of N+1 cycles.

Reset
REQ-027 When reset=1 at a rising edge, the block SHALL:
- set hi=0, lo=0 and busy=0;
- set the FSM to IDLE and the counter to 0;
- clear the pending registers.
REQ-028 Reset SHALL take priority over start, flush and counter expiry.
- An in-flight operation interrupted by reset SHALL be discarded with no hi/lo update.

Verification
REQ-029 The bench SHALL apply mult with rs=0xFFFFFFFF, rt=2 and check the following.
- busy=1 for exactly 5 cycles.
- The cycle after, hi=0xFFFFFFFF and lo=0xFFFFFFFE.
- The same operands with multu give hi=0x00000001 and lo=0xFFFFFFFE.
REQ-030 The bench SHALL apply div with rs=0xFFFFFFF9 (-7), rt=2 and check the following.
- busy=1 for exactly 10 cycles.
- Then lo=0xFFFFFFFD (-3) and hi=0xFFFFFFFF (-1).
REQ-031 The bench SHALL apply mthi 0x12345678, then mtlo 0x9ABCDEF0, on consecutive cycles and check the following.
- hi and lo update on successive edges.
- busy stays 0 throughout.
REQ-032 The bench SHALL assert start=1, op=001 with flush=1 and check that busy stays 0 and hi/lo are unchanged.
- It SHALL then assert flush=1 during cycle 2 of a busy mult and check that the result is still written after cycle 5.
REQ-033 The bench SHALL issue divu with rt=0 after preloading hi=0xAAAA and lo=0x5555 and check the following.
- busy=1 for 10 cycles.
- hi=0xAAAA and lo=0x5555 afterwards.
REQ-034 The bench SHALL assert reset during cycle 3 of a div and check the following.
- The next cycle has busy=0, hi=0 and lo=0.
- A start issued in the same cycle as reset is ignored.
